// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority resolver.
// Rotating priority is compiled in only when DMA_ROTATING_PRIORITY_EN is defined.
package dma_pkg;

    localparam int NUM_CH_DEFAULT = 4;
    localparam int CH_W           = 2;

    // Bit positions inside commandReg.
    localparam int CMD_DISABLE   = 2;
    localparam int CMD_ROTATE    = 4;
    localparam int CMD_DREQ_LOW  = 6;
    localparam int CMD_DACK_HIGH = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dma_prio_pick.sv
// Combinational winner select: request vector plus last-serviced pointer gives a channel index.
// The highest-priority channel is 0 when fixed, or the one after i_last_ch when rotating.
module dma_prio_pick
    import dma_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_rotate,
    input  logic [CH_W-1:0]   i_last_ch,
    output logic              o_valid,
    output logic [CH_W-1:0]   o_idx
);

    int              w_ch;
    logic [CH_W-1:0] w_ch_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        o_valid  = 1'b0;
        o_idx    = '0;
        w_ch     = 0;
        w_ch_idx = '0;
        // Walk from lowest to highest priority so the best requester is written last.
        for (int rank = NUM_CH - 1; rank >= 0; rank--) begin
            w_ch     = i_rotate ? (int'(i_last_ch) + 1 + rank) % NUM_CH : rank;
            w_ch_idx = CH_W'(w_ch);
            if (i_req[w_ch_idx]) begin
                o_valid = 1'b1;
                o_idx   = w_ch_idx;
            end
        end
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA channel priority resolver: IDLE -> REQ -> GRANT handshake with HRQ/HLDA and per-channel DACK.
// Define DMA_ROTATING_PRIORITY_EN to honour commandReg[4] rotating priority; otherwise fixed priority.
module dma_priority_resolver
    import dma_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [7:0]        commandReg,
    input  logic [7:0]        requestReg,
    input  logic [7:0]        maskReg,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [1:0]        grantCh
);

    dma_state_e        r_state;
    logic [NUM_CH-1:0] r_dreq;
    logic [NUM_CH-1:0] r_active;
    logic              r_hrq;
    logic              r_grant_valid;
    logic [CH_W-1:0]   r_grant_ch;

    logic [NUM_CH-1:0] w_eff_req;
    logic              w_any_req;
    logic              w_rotate;
    logic [CH_W-1:0]   w_last_ch;
    logic              w_pick_valid;
    logic [CH_W-1:0]   w_pick_idx;
    logic              w_unused;

    assign w_eff_req = commandReg[CMD_DISABLE] ? '0
                     : (r_dreq | requestReg[NUM_CH-1:0]) & ~maskReg[NUM_CH-1:0];
    assign w_any_req = |w_eff_req;

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [CH_W-1:0] r_last_ch;

    assign w_rotate  = commandReg[CMD_ROTATE];
    assign w_last_ch = r_last_ch;
    assign w_unused  = ^{commandReg[5], commandReg[3], commandReg[1:0],
                         requestReg[7:NUM_CH], maskReg[7:NUM_CH]};

    // Pointer moves only on a completed service; an HLDA abort leaves it alone.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last_ch <= CH_W'(NUM_CH - 1);
        end else if (r_state == ST_GRANT && serviceDone) begin
            r_last_ch <= r_grant_ch;
        end
    end
`else
    assign w_rotate  = 1'b0;
    assign w_last_ch = CH_W'(NUM_CH - 1);
    assign w_unused  = ^{commandReg[5], commandReg[CMD_ROTATE], commandReg[3], commandReg[1:0],
                         requestReg[7:NUM_CH], maskReg[7:NUM_CH]};
`endif

    dma_prio_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .i_req     (w_eff_req),
        .i_rotate  (w_rotate),
        .i_last_ch (w_last_ch),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    // NOTE: all state updates use <= so every branch sees the pre-edge values of the other registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_dreq        <= '0;
            r_active      <= '0;
            r_hrq         <= 1'b0;
            r_grant_valid <= 1'b0;
            r_grant_ch    <= '0;
        end else begin
            r_dreq <= DREQ ^ {NUM_CH{commandReg[CMD_DREQ_LOW]}};
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_REQ;
                        r_hrq   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!w_any_req) begin
                        r_state <= ST_IDLE;
                        r_hrq   <= 1'b0;
                    end else if (HLDA && w_pick_valid) begin
                        r_state       <= ST_GRANT;
                        r_grant_ch    <= w_pick_idx;
                        r_grant_valid <= 1'b1;
                        r_active      <= NUM_CH'(1) << w_pick_idx;
                    end
                end
                ST_GRANT: begin
                    // Completion and HLDA abort release the bus identically.
                    if (serviceDone || !HLDA) begin
                        r_state       <= ST_IDLE;
                        r_hrq         <= 1'b0;
                        r_grant_valid <= 1'b0;
                        r_active      <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign HRQ        = r_hrq;
    assign grantValid = r_grant_valid;
    assign grantCh    = r_grant_ch;
    assign DACK       = commandReg[CMD_DACK_HIGH] ? r_active : ~r_active;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench for dma_priority_resolver: directed scenarios plus randomized request rounds
// scored against a rank-based priority model (rotation expected only when DMA_ROTATING_PRIORITY_EN).
`timescale 1ns/1ps
module tb_dma_priority_resolver;

    localparam int N = 4;
`ifdef DMA_ROTATING_PRIORITY_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RESET;
    logic [N-1:0] DREQ;
    logic [7:0]   commandReg;
    logic [7:0]   requestReg;
    logic [7:0]   maskReg;
    logic         HLDA;
    logic         serviceDone;
    logic         HRQ;
    logic [N-1:0] DACK;
    logic         grantValid;
    logic [1:0]   grantCh;

    int n_tests = 0;
    int n_fail  = 0;
    int model_last = N - 1;

    always #5 CLK = ~CLK;

    dma_priority_resolver #(.NUM_CH(N)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DREQ        (DREQ),
        .commandReg  (commandReg),
        .requestReg  (requestReg),
        .maskReg     (maskReg),
        .HLDA        (HLDA),
        .serviceDone (serviceDone),
        .HRQ         (HRQ),
        .DACK        (DACK),
        .grantValid  (grantValid),
        .grantCh     (grantCh)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = requesting channel with the smallest priority rank.
    function automatic int model_pick(input logic [3:0] eff, input int last, input bit rot);
        int best      = -1;
        int best_rank = 1000;
        for (int c = 0; c < N; c++) begin
            if (eff[c]) begin
                int rank = rot ? (c - last - 1 + 2 * N) % N : c;
                if (rank < best_rank) begin
                    best_rank = rank;
                    best      = c;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] exp_dack(input int ch, input bit high);
        logic [3:0] v = 4'b0001 << ch;
        return high ? v : ~v;
    endfunction

    task automatic do_reset();
        HLDA        = 1'b0;
        serviceDone = 1'b0;
        RESET       = 1'b1;
        step();
        RESET       = 1'b0;
        model_last  = N - 1;
    endtask

    task automatic wait_hrq(input string tag);
        int n = 0;
        while (HRQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_hrq_rise"}, HRQ, 1);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (grantValid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_grant_valid"}, grantValid, 1);
    endtask

    // HLDA is raised two cycles after HRQ is seen.
    task automatic do_grant(input string tag);
        wait_hrq(tag);
        step();
        step();
        HLDA = 1'b1;
        wait_grant(tag);
    endtask

    task automatic serve(input string tag, input int exp_ch);
        serviceDone = 1'b1;
        step();
        serviceDone = 1'b0;
        HLDA        = 1'b0;
        check({tag, "_done_hrq"}, HRQ, 0);
        check({tag, "_done_gv"}, grantValid, 0);
        check({tag, "_done_dack"}, DACK, {4{~commandReg[7]}});
        model_last = exp_ch;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cmd;
        logic [3:0] dreq_act;
        logic [3:0] eff;
        int         exp_ch;

        DREQ = '0; commandReg = 8'h00; requestReg = 8'h00; maskReg = 8'h00;
        HLDA = 1'b0; serviceDone = 1'b0; RESET = 1'b1;
        step();
        step();
        check("rst_hrq", HRQ, 0);
        check("rst_gv", grantValid, 0);
        check("rst_ch", grantCh, 0);
        check("rst_dack", DACK, 4'b1111);
        RESET = 1'b0;

        // Fixed priority, DREQ 1010 -> ch1, and ch1 again on the next round.
        commandReg = 8'h00;
        DREQ = 4'b1010;
        do_grant("fix1");
        check("fix1_ch", grantCh, 1);
        check("fix1_dack", DACK, 4'b1101);
        serve("fix1", 1);
        do_grant("fix2");
        check("fix2_ch", grantCh, 1);
        serve("fix2", 1);

        // Rotating, all four requesting: 0,1,2,3,0 (fixed build: always 0).
        DREQ = 4'b0000;
        do_reset();
        commandReg = 8'h10;
        DREQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_ch = ROT_EN ? (i % N) : 0;
            do_grant("rot");
            check($sformatf("rot%0d_ch", i), grantCh, exp_ch);
            check($sformatf("rot%0d_dack", i), DACK, exp_dack(exp_ch, 1'b0));
            serve("rot", exp_ch);
        end

        // Mask and software request, then controller disable.
        DREQ = 4'b0000;
        do_reset();
        commandReg = 8'h00;
        maskReg = 8'h01;
        DREQ = 4'b0001;
        requestReg = 8'h04;
        do_grant("mask");
        check("mask_ch", grantCh, 2);
        serve("mask", 2);
        commandReg = 8'h04;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("dis%0d_hrq", i), HRQ, 0);
        end
        maskReg = 8'h00;
        requestReg = 8'h00;

        // HLDA abort on ch2, then retry with all requesting -> ch0 (pointer unchanged).
        DREQ = 4'b0000;
        commandReg = 8'h10;
        do_reset();
        DREQ = 4'b0100;
        do_grant("abort");
        check("abort_ch", grantCh, 2);
        HLDA = 1'b0;
        step();
        check("abort_hrq", HRQ, 0);
        check("abort_gv", grantValid, 0);
        check("abort_dack", DACK, 4'b1111);
        DREQ = 4'b1111;
        do_grant("retry");
        check("retry_ch", grantCh, 0);
        serve("retry", 0);

        // Polarity: DREQ active-low, DACK active-high; reset mid-GRANT.
        DREQ = 4'b1111;
        commandReg = 8'hC0;
        do_reset();
        DREQ = 4'b1110;
        do_grant("pol");
        check("pol_ch", grantCh, 0);
        check("pol_dack", DACK, 4'b0001);
        RESET = 1'b1;
        step();
        check("midrst_hrq", HRQ, 0);
        check("midrst_gv", grantValid, 0);
        check("midrst_ch", grantCh, 0);
        check("midrst_dack", DACK, 4'b0000);
        RESET = 1'b0;
        HLDA = 1'b0;

        // Randomized rounds against the model.
        maskReg = 8'hFF;
        commandReg = 8'h00;
        DREQ = 4'b0000;
        do_reset();
        for (int r = 0; r < 24; r++) begin
            cmd = {1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 4'b0000};
            dreq_act = 4'($urandom);
            commandReg = cmd;
            DREQ = dreq_act ^ {4{cmd[6]}};
            requestReg = {4'b0000, 4'($urandom) & 4'($urandom)};
            maskReg = {4'b0000, 4'($urandom) & 4'($urandom)};
            eff = (dreq_act | requestReg[3:0]) & ~maskReg[3:0];
            if (eff == 4'b0000) begin
                repeat (4) step();
                check($sformatf("rnd%0d_idle_hrq", r), HRQ, 0);
            end else begin
                exp_ch = model_pick(eff, model_last, cmd[4] & ROT_EN);
                do_grant($sformatf("rnd%0d", r));
                check($sformatf("rnd%0d_ch", r), grantCh, exp_ch);
                check($sformatf("rnd%0d_dack", r), DACK, exp_dack(exp_ch, cmd[7]));
                serve($sformatf("rnd%0d", r), exp_ch);
            end
            maskReg = 8'hFF;
            repeat (3) step();
            check($sformatf("rnd%0d_park_hrq", r), HRQ, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
